// File: rtl/trng_pkg.sv
// Shared types and defaults for the NLFSR sequencing controller.
// FSM encoding plus default geometry of seed, init and output words.
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int DEF_SEED_W      = 16;
  localparam int DEF_INIT_CYCLES = 64;
  localparam int DEF_WORD_W      = 8;
  localparam int FIFO_DEPTH      = 2;

endpackage

// File: rtl/nlfsr_seq_ctrl_if.sv
// Valid/ready word stream from the sequencer to its consumer.
// The master drives data/valid, the slave drives ready.
interface nlfsr_seq_ctrl_if
  import trng_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
);

  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/trng_word_fifo.sv
// Two-entry word FIFO; a push into a full FIFO succeeds
// when a pop frees the head in the same cycle.
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    cnt_d    = cnt_q + {1'b0, do_push}
                     - {1'b0, do_pop};
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/nlfsr_seq_ctrl.sv
// Sequences an external NLFSR through seed load and warbler init,
// then packs its output bits into words behind a 2-deep FIFO.
module nlfsr_seq_ctrl
  import trng_pkg::*;
#(
  parameter int SEED_W      = DEF_SEED_W,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int WORD_W      = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [SEED_W-1:0] seed,
  input  logic              nlfsr_b0,
  output logic              nlfsr_load,
  output logic              nlfsr_d,
  output logic              nlfsr_init,
  output logic              nlfsr_ce,
  output logic              busy,
  output logic              overrun,
  nlfsr_seq_ctrl_if.master  wo
);

  localparam int LCW = $clog2(SEED_W + 1);
  localparam int ICW = $clog2(INIT_CYCLES + 1);
  localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_e            state_q, state_d;
  logic [SEED_W-1:0] shift_q, shift_d;
  logic [LCW-1:0]    load_cnt_q, load_cnt_d;
  logic [ICW-1:0]    init_cnt_q, init_cnt_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic              load_last;
  logic              init_last;
  logic              word_last;
  logic [WORD_W-1:0] word_w;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign accept    = (state_q == ST_IDLE) & start;
  assign load_last = (load_cnt_q == LCW'(SEED_W - 1));
  assign init_last = (init_cnt_q == ICW'(INIT_CYCLES - 1));
  assign word_last = (bit_cnt_q == BCW'(WORD_W - 1));
  assign pop       = wo.word_valid & wo.word_ready;
  assign overrun   = overrun_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (stop)           state_d = ST_IDLE;
        else if (load_last) state_d = ST_INIT;
      end
      ST_INIT: begin
        if (stop)           state_d = ST_IDLE;
        else if (init_last) state_d = ST_RUN;
      end
      ST_RUN:  if (stop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    nlfsr_load = 1'b0;
    nlfsr_d    = 1'b0;
    nlfsr_init = 1'b0;
    nlfsr_ce   = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_LOAD: begin
        nlfsr_load = 1'b1;
        nlfsr_d    = shift_q[0];
      end
      ST_INIT: begin
        nlfsr_init = 1'b1;
        nlfsr_ce   = 1'b1;
      end
      ST_RUN:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    load_cnt_d = load_cnt_q;
    init_cnt_d = init_cnt_q;
    pack_d     = pack_q;
    bit_cnt_d  = bit_cnt_q;
    overrun_d  = overrun_q;
    push       = 1'b0;
    word_w     = pack_q;
    word_w[bit_cnt_q] = nlfsr_b0;
    if (accept) begin
      shift_d    = seed;
      load_cnt_d = '0;
      init_cnt_d = '0;
      pack_d     = '0;
      bit_cnt_d  = '0;
      overrun_d  = 1'b0;
    end else if (state_q == ST_LOAD && !stop) begin
      shift_d    = shift_q >> 1;
      load_cnt_d = load_cnt_q + LCW'(1);
    end else if (state_q == ST_INIT && !stop) begin
      init_cnt_d = init_cnt_q + ICW'(1);
    end else if (state_q == ST_RUN && !stop) begin
      if (word_last) begin
        push      = 1'b1;
        pack_d    = '0;
        bit_cnt_d = '0;
      end else begin
        pack_d    = word_w;
        bit_cnt_d = bit_cnt_q + BCW'(1);
      end
    end else if (state_q == ST_RUN) begin
      // stop drops the partial word; buffered words stay drainable
      pack_d    = '0;
      bit_cnt_d = '0;
    end
    if (push && fifo_full && !pop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q    <= '0;
      load_cnt_q <= '0;
      init_cnt_q <= '0;
      pack_q     <= '0;
      bit_cnt_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      load_cnt_q <= load_cnt_d;
      init_cnt_q <= init_cnt_d;
      pack_q     <= pack_d;
      bit_cnt_q  <= bit_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  trng_word_fifo #(
    .WORD_W (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (word_w),
    .pop       (pop),
    .head      (wo.word_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wo.word_valid = ~fifo_empty;

endmodule

// File: tb/tb_nlfsr_seq_ctrl.sv
// Directed bench for nlfsr_seq_ctrl: load, init, packing,
// overrun, stop and reset behaviour with hand-computed values.
module tb_nlfsr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] seed = '0;
  logic        b0 = 1'b0;
  logic        nlfsr_load;
  logic        nlfsr_d;
  logic        nlfsr_init;
  logic        nlfsr_ce;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  nlfsr_seq_ctrl_if #(.WORD_W(8)) wif ();

  nlfsr_seq_ctrl #(
    .SEED_W      (16),
    .INIT_CYCLES (4),
    .WORD_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .seed       (seed),
    .nlfsr_b0   (b0),
    .nlfsr_load (nlfsr_load),
    .nlfsr_d    (nlfsr_d),
    .nlfsr_init (nlfsr_init),
    .nlfsr_ce   (nlfsr_ce),
    .busy       (busy),
    .overrun    (overrun),
    .wo         (wif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_bits(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      b0 = w[i];
      step();
    end
  endtask

  logic [15:0] d_exp;

  initial begin
    wif.word_ready = 1'b0;
    d_exp = 16'hA5C3;

    // reset state
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_load", nlfsr_load, 0);
    chk("rst_init", nlfsr_init, 0);
    chk("rst_valid", wif.word_valid, 0);
    chk("rst_data", wif.word_data, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b1;
    step();

    // seed load, with an ignored start mid-load
    start = 1'b1;
    seed  = 16'hA5C3;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("load_sel", nlfsr_load, 1);
      chk("load_d", nlfsr_d, d_exp[i]);
      start = (i == 5);
      seed  = (i == 5) ? 16'h0000 : 16'hA5C3;
      step();
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("init_sel", nlfsr_init, 1);
      chk("init_ce", nlfsr_ce, 1);
      chk("init_load", nlfsr_load, 0);
      step();
    end
    chk("run_busy", busy, 1);
    chk("run_init", nlfsr_init, 0);
    chk("run_ce", nlfsr_ce, 0);
    chk("run_load", nlfsr_load, 0);
    chk("run_d", nlfsr_d, 0);
    chk("run_valid0", wif.word_valid, 0);

    // first word 1,0,1,1,0,0,0,0 -> 0x0D
    wif.word_ready = 1'b1;
    run_bits(8'h0D);
    chk("w0_valid", wif.word_valid, 1);
    chk("w0_data", wif.word_data, 8'h0D);
    b0 = 1'b0;
    step();
    chk("w0_popped", wif.word_valid, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_run", busy, 0);

    // overrun: two buffered, third dropped
    start = 1'b1;
    seed  = 16'h1234;
    step();
    start = 1'b0;
    repeat (20) step();
    wif.word_ready = 1'b0;
    run_bits(8'h3C);
    run_bits(8'hA1);
    chk("full_no_ovr", overrun, 0);
    chk("full_head", wif.word_data, 8'h3C);
    run_bits(8'hFF);
    chk("ovr_set", overrun, 1);
    chk("ovr_valid", wif.word_valid, 1);
    chk("ovr_head", wif.word_data, 8'h3C);
    wif.word_ready = 1'b1;
    b0 = 1'b0;
    step();
    chk("drain1", wif.word_data, 8'hA1);
    chk("drain1_v", wif.word_valid, 1);
    step();
    chk("drain2_v", wif.word_valid, 0);
    chk("ovr_sticky", overrun, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_ovr", overrun, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_idle", busy, 0);

    // start+stop in IDLE loads; accepted start clears overrun
    start = 1'b1;
    stop  = 1'b1;
    seed  = 16'h00FF;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", busy, 1);
    chk("ss_load", nlfsr_load, 1);
    chk("start_clr_ovr", overrun, 0);
    repeat (20) step();
    wif.word_ready = 1'b0;
    run_bits(8'h11);
    chk("pp_head", wif.word_data, 8'h11);
    run_bits(8'h22);
    for (int i = 0; i < 8; i++) begin
      b0 = i[0] | i[1] ? 1'b1 : 1'b0;
      b0 = (8'h33 >> i) & 8'h01 ? 1'b1 : 1'b0;
      wif.word_ready = (i == 7);
      step();
    end
    wif.word_ready = 1'b0;
    chk("pp_no_ovr", overrun, 0);
    chk("pp_head2", wif.word_data, 8'h22);
    wif.word_ready = 1'b1;
    step();
    wif.word_ready = 1'b0;
    chk("pp_head3", wif.word_data, 8'h33);
    chk("pp_valid3", wif.word_valid, 1);

    // reset mid-run with one word buffered
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_valid", wif.word_valid, 0);
    chk("mrst_data", wif.word_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ovr", overrun, 0);
    chk("mrst_sel", {nlfsr_load, nlfsr_d, nlfsr_init, nlfsr_ce}, 0);
    step();
    chk("mrst_idle", busy, 0);

    // stop during INIT cycle 2
    start = 1'b1;
    seed  = 16'hFFFF;
    step();
    start = 1'b0;
    repeat (16) step();
    chk("i1_init", nlfsr_init, 1);
    step();
    chk("i2_init", nlfsr_init, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("istop_init", nlfsr_init, 0);
    chk("istop_ce", nlfsr_ce, 0);
    chk("istop_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nlfsr_seq_ctrl.md
NLFSR_SEQ_CTRL -- requirements
Module: nlfsr_seq_ctrl

Interface
REQ-001 SHALL have parameter SEED_W, default 16, NLFSR length / seed bits shifted in LOAD.
REQ-002 SHALL have parameter INIT_CYCLES, default 64, warbler-mixing cycles in INIT (legal 1..1023).
REQ-003 SHALL have parameter WORD_W, default 8, bits packed per output word.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset (asserted when 0).
REQ-006 start  in  1  pulse; begins seed load from IDLE, ignored elsewhere.
REQ-007 stop  in  1  pulse; aborts LOAD/INIT/RUN back to IDLE.
REQ-008 seed  in  SEED_W  seed value, sampled on accepted start.
REQ-009 nlfsr_b0  in  1  NLFSR output bit b0.
REQ-010 nlfsr_load  out  1  NLFSR load select (serial seed entry).
REQ-011 nlfsr_d  out  1  NLFSR serial seed bit (d2).
REQ-012 nlfsr_init  out  1  NLFSR init-phase select.
REQ-013 nlfsr_ce  out  1  NLFSR warbler-mix enable.
REQ-014 busy  out  1  high in LOAD, INIT, RUN.
REQ-015 word_data  out  WORD_W  packed random word at FIFO head.
REQ-016 word_valid  out  1  FIFO non-empty.
REQ-017 word_ready  in  1  consumer accept; transfer when valid&ready.
REQ-018 overrun  out  1  sticky; a completed word was dropped.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, INIT, RUN; IDLE->LOAD on start; LOAD->INIT after SEED_W cycles; INIT->RUN after INIT_CYCLES cycles; RUN holds until stop.
REQ-020 stop SHALL force IDLE next cycle from LOAD/INIT/RUN; stop in IDLE ignored; start and stop same cycle in IDLE -> LOAD (stop ignored).
REQ-021 LOAD: nlfsr_load=1, nlfsr_d = seed shift copy bit 0, shift copy right each cycle, so seed[0] sits at b0 after SEED_W cycles.
REQ-022 INIT: nlfsr_load=0, nlfsr_init=1, nlfsr_ce=1; cycle counter width ceil(log2(INIT_CYCLES+1)).
REQ-023 IDLE and RUN: nlfsr_load=0, nlfsr_init=0, nlfsr_ce=0, nlfsr_d=0.
REQ-024 RUN: each cycle SHALL shift nlfsr_b0 into packer LSB-first (first bit -> bit 0); first RUN-cycle sample is bit 0 of word 0.
REQ-025 Completed word SHALL be written to a 2-entry FIFO in the cycle its WORD_W-th bit is sampled, visible at word_valid next cycle.
REQ-026 FIFO full at completion (pop same cycle frees space and SHALL allow the write) -> word dropped, overrun=1.
REQ-027 overrun SHALL clear only on reset or accepted start.
REQ-028 stop SHALL discard partial packer word; FIFO contents retained and drainable in IDLE.
REQ-029 Accepted start SHALL clear packer and bit counter, not the FIFO.
REQ-030 word_data/word_valid SHALL be stable while valid&!ready.

Reset
REQ-031 On rst=0 at clock edge: state IDLE, counters 0, FIFO empty, word_valid=0, word_data=0, overrun=0, busy=0, all nlfsr_* outputs 0.
REQ-032 Reset mid-operation SHALL take effect next edge regardless of state; start while rst=0 ignored.

Structure
REQ-033 FSM state enum and default parameter constants SHALL live in shared package trng_pkg.
REQ-034 Output FIFO SHALL be sub-module trng_word_fifo (depth 2, WORD_W wide, full/empty, simultaneous push/pop).
REQ-035 Block SHALL NOT instantiate the NLFSR; the integrating top connects nlfsr_* to it.

Verification
REQ-036 seed=16'hA5C3, start, INIT_CYCLES=4 -> nlfsr_d sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 with nlfsr_load=1 for 16 cycles, then init=ce=1 exactly 4 cycles, then busy=1 with all selects 0.
REQ-037 RUN, nlfsr_b0 driven 1,0,1,1,0,0,0,0 from first RUN cycle, word_ready=1 -> word_data=8'h0D with word_valid one cycle after 8th bit.
REQ-038 RUN, word_ready=0 for 24 cycles -> two words buffered, third dropped, overrun=1; then ready=1 -> exactly two words drained, overrun stays 1 until next start.
REQ-039 stop in INIT cycle 2 -> IDLE next cycle, nlfsr_init=nlfsr_ce=0, busy=0; start in LOAD ignored (load still ends after 16 cycles).
REQ-040 rst=0 for one cycle mid-RUN with FIFO holding 1 word -> all outputs at reset values next cycle, FIFO empty.
